// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Output-group vectors are ordered {pc_write, if_id_write, if_id_flush, id_ex_bubble}.
package pipe_ctrl_pkg;

   localparam int unsigned RegWDefault = 5;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StLuStall = 2'd1,
      StMemWait = 2'd2
   } ctrl_state_e;

   localparam logic [3:0] CtrlNormal = 4'b1100;
   localparam logic [3:0] CtrlStall  = 4'b0001;
   localparam logic [3:0] CtrlFreeze = 4'b0000;
   localparam logic [3:0] CtrlFlush  = 4'b1111;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector: the load in EX writes a register the ID
// instruction reads. Register 0 is hardwired and never creates a hazard.
module hazard_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = RegWDefault
) (
   input  logic [REG_W-1:0] i_id_rs,
   input  logic [REG_W-1:0] i_id_rt,
   input  logic             i_id_uses_rt,
   input  logic             i_ex_mem_read,
   input  logic [REG_W-1:0] i_ex_rt,
   output logic             o_lu_hit
);

   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = (i_ex_rt == i_id_rs);
   assign w_rt_match = i_id_uses_rt & (i_ex_rt == i_id_rt);
   assign o_lu_hit   = i_ex_mem_read & (i_ex_rt != '0) & (w_rs_match | w_rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush and memory-wait freeze.
// Optional saturating perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned LU_STALL_CYCLES = 1,
   parameter int unsigned REG_W           = RegWDefault,
   parameter int unsigned PERF_W          = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [REG_W-1:0]  i_id_rs,
   input  logic [REG_W-1:0]  i_id_rt,
   input  logic              i_id_uses_rt,
   input  logic              i_ex_mem_read,
   input  logic [REG_W-1:0]  i_ex_rt,
   input  logic              i_branch_taken,
   input  logic              i_dmem_busy,
   output logic              o_pc_write,
   output logic              o_if_id_write,
   output logic              o_if_id_flush,
   output logic              o_id_ex_bubble,
`ifdef PIPE_CTRL_PERF_EN
   output logic [PERF_W-1:0] o_stall_count,
   output logic [PERF_W-1:0] o_flush_count,
`endif
   output logic [1:0]        o_ctrl_state
);

   // Remaining stall cycles after the first one, which is issued from StRun.
   localparam logic [1:0] LuLoad = 2'(LU_STALL_CYCLES - 1);

   if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 3 || PERF_W < 1) begin : g_param_check
      $error("pipeline_ctrl: LU_STALL_CYCLES must be 1..3 and PERF_W at least 1");
   end

   ctrl_state_e r_state;
   ctrl_state_e r_resume;
   logic [1:0]  r_cnt;

   ctrl_state_e w_state_nxt;
   ctrl_state_e w_resume_nxt;
   ctrl_state_e w_dec_state;
   logic [1:0]  w_cnt_nxt;
   logic        w_lu_hit;
   logic [3:0]  w_grp;

   hazard_detect #(
      .REG_W (REG_W)
   ) u_hazard_detect (
      .i_id_rs       (i_id_rs),
      .i_id_rt       (i_id_rt),
      .i_id_uses_rt  (i_id_uses_rt),
      .i_ex_mem_read (i_ex_mem_read),
      .i_ex_rt       (i_ex_rt),
      .o_lu_hit      (w_lu_hit)
   );

   // Once memory is ready, MEM_WAIT behaves exactly like the state it interrupted.
   always_comb begin
      w_dec_state = r_state;
      if (r_state == StMemWait && !i_dmem_busy) begin
         w_dec_state = r_resume;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StRun;
         r_resume <= StRun;
         r_cnt    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_resume <= w_resume_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_resume_nxt = r_resume;
      w_cnt_nxt    = r_cnt;
      case (w_dec_state)
         StRun: begin
            if (i_dmem_busy) begin
               w_state_nxt  = StMemWait;
               w_resume_nxt = StRun;
            end else if (i_branch_taken) begin
               w_state_nxt = StRun;
            end else if (w_lu_hit && LU_STALL_CYCLES > 1) begin
               w_cnt_nxt   = LuLoad;
               w_state_nxt = StLuStall;
            end else begin
               w_state_nxt = StRun;
            end
         end
         StLuStall: begin
            if (i_dmem_busy) begin
               w_state_nxt  = StMemWait;
               w_resume_nxt = StLuStall;
            end else if (i_branch_taken) begin
               w_cnt_nxt   = '0;
               w_state_nxt = StRun;
            end else if (r_cnt > 2'd1) begin
               w_cnt_nxt   = r_cnt - 2'd1;
               w_state_nxt = StLuStall;
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = StRun;
            end
         end
         StMemWait: begin
            w_state_nxt = i_dmem_busy ? StMemWait : StRun;
         end
         default: begin
            w_state_nxt  = StRun;
            w_resume_nxt = StRun;
            w_cnt_nxt    = '0;
         end
      endcase
   end

   always_comb begin
      w_grp = CtrlNormal;
      case (w_dec_state)
         StRun: begin
            if (i_dmem_busy) begin
               w_grp = CtrlFreeze;
            end else if (i_branch_taken) begin
               w_grp = CtrlFlush;
            end else if (w_lu_hit) begin
               w_grp = CtrlStall;
            end else begin
               w_grp = CtrlNormal;
            end
         end
         StLuStall: begin
            if (i_dmem_busy) begin
               w_grp = CtrlFreeze;
            end else if (i_branch_taken) begin
               w_grp = CtrlFlush;
            end else begin
               w_grp = CtrlStall;
            end
         end
         StMemWait: w_grp = CtrlFreeze;
         default:   w_grp = CtrlNormal;
      endcase
   end

   assign {o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_bubble} = w_grp;
   assign o_ctrl_state = r_state;

`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] r_stall_count;
   logic [PERF_W-1:0] r_flush_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (!w_grp[3] && r_stall_count != '1) begin
            r_stall_count <= r_stall_count + 1'b1;
         end
         if (w_grp[1] && r_flush_count != '1) begin
            r_flush_count <= r_flush_count + 1'b1;
         end
      end
   end

   assign o_stall_count = r_stall_count;
   assign o_flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (stall length 1 and 3) share stimulus and are
// compared each cycle against a cycle-owed reference model. Perf checks need PIPE_CTRL_PERF_EN.
module tb_pipeline_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, branch_taken, dmem_busy;

   logic [3:0] g1, g3;
   logic [1:0] st1, st3;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] sc1, fc1, sc3, fc3;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: cycles of stall still owed, observable state, perf tallies.
   int owed [2];
   int mst  [2];
   int scnt [2];
   int fcnt [2];
   int len  [2];

   always #5 clk = ~clk;

   pipeline_ctrl #(.LU_STALL_CYCLES(1), .REG_W(5), .PERF_W(32)) u_dut1 (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_id_rs        (id_rs),
      .i_id_rt        (id_rt),
      .i_id_uses_rt   (id_uses_rt),
      .i_ex_mem_read  (ex_mem_read),
      .i_ex_rt        (ex_rt),
      .i_branch_taken (branch_taken),
      .i_dmem_busy    (dmem_busy),
      .o_pc_write     (g1[3]),
      .o_if_id_write  (g1[2]),
      .o_if_id_flush  (g1[1]),
      .o_id_ex_bubble (g1[0]),
`ifdef PIPE_CTRL_PERF_EN
      .o_stall_count  (sc1),
      .o_flush_count  (fc1),
`endif
      .o_ctrl_state   (st1)
   );

   pipeline_ctrl #(.LU_STALL_CYCLES(3), .REG_W(5), .PERF_W(32)) u_dut3 (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_id_rs        (id_rs),
      .i_id_rt        (id_rt),
      .i_id_uses_rt   (id_uses_rt),
      .i_ex_mem_read  (ex_mem_read),
      .i_ex_rt        (ex_rt),
      .i_branch_taken (branch_taken),
      .i_dmem_busy    (dmem_busy),
      .o_pc_write     (g3[3]),
      .o_if_id_write  (g3[2]),
      .o_if_id_flush  (g3[1]),
      .o_id_ex_bubble (g3[0]),
`ifdef PIPE_CTRL_PERF_EN
      .o_stall_count  (sc3),
      .o_flush_count  (fc3),
`endif
      .o_ctrl_state   (st3)
   );

   function automatic logic lu_hit_f();
      return ex_mem_read && ex_rt != 5'd0 &&
             (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
   endfunction

   // {pc_write, if_id_write, flush, bubble}
   function automatic logic [3:0] exp_grp(int k);
      if (dmem_busy)    return 4'b0000;
      if (branch_taken) return 4'b1111;
      if (owed[k] > 0)  return 4'b0001;
      if (lu_hit_f())   return 4'b0001;
      return 4'b1100;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_model();
      check("grp_lu1", {28'd0, g1}, {28'd0, exp_grp(0)});
      check("grp_lu3", {28'd0, g3}, {28'd0, exp_grp(1)});
      check("state_lu1", {30'd0, st1}, mst[0]);
      check("state_lu3", {30'd0, st3}, mst[1]);
`ifdef PIPE_CTRL_PERF_EN
      check("stall_cnt_lu1", sc1, scnt[0]);
      check("stall_cnt_lu3", sc3, scnt[1]);
      check("flush_cnt_lu1", fc1, fcnt[0]);
      check("flush_cnt_lu3", fc3, fcnt[1]);
`endif
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         owed[k] = 0;
         mst[k]  = 0;
         scnt[k] = 0;
         fcnt[k] = 0;
      end
   endtask

   task automatic tick();
      logic [3:0] g;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         g = exp_grp(k);
         if (!g[3]) scnt[k]++;
         if (g[1])  fcnt[k]++;
         if (!dmem_busy) begin
            if (branch_taken)    owed[k] = 0;
            else if (owed[k] > 0) owed[k]--;
            else if (lu_hit_f()) owed[k] = len[k] - 1;
         end
         mst[k] = dmem_busy ? 2 : (owed[k] > 0 ? 1 : 0);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic mr, input logic [4:0] ert, input logic br,
                        input logic busy);
      @(negedge clk);
      id_rs = rs; id_rt = rt; id_uses_rt = uses;
      ex_mem_read = mr; ex_rt = ert; branch_taken = br; dmem_busy = busy;
      #1;
   endtask

   task automatic set_idle();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; ex_rt = 5'd0; branch_taken = 1'b0; dmem_busy = 1'b0;
   endtask

   // Called during the low clock phase; asserts reset, checks, releases before the edge.
   task automatic do_reset();
      rst_n = 1'b0;
      set_idle();
      #1;
      model_reset();
      check("rst_grp_lu1", {28'd0, g1}, 32'hC);
      check("rst_grp_lu3", {28'd0, g3}, 32'hC);
      check("rst_state_lu1", {30'd0, st1}, 32'd0);
      check("rst_state_lu3", {30'd0, st3}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
      check("rst_stall_cnt", sc3, 32'd0);
      check("rst_flush_cnt", fc3, 32'd0);
`endif
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      len[0] = 1;
      len[1] = 3;
      rst_n = 1'b1;
      set_idle();
      @(negedge clk);
      do_reset();

      // Load-use with 3-cycle stall, memory wait during the 2nd stall cycle.
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      check("lu3_c0", {28'd0, g3}, 32'h1);
      check_model(); tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      check("lu3_c1", {28'd0, g3}, 32'h0);
      check_model(); tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      check("lu3_c2", {28'd0, g3}, 32'h0);
      check_model(); tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("lu3_c3", {28'd0, g3}, 32'h1);
      check_model(); tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("lu3_c4", {28'd0, g3}, 32'h1);
      check_model(); tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("lu3_c5", {28'd0, g3}, 32'hC);
      check("lu3_c5_state", {30'd0, st3}, 32'd0);
`ifdef PIPE_CTRL_PERF_EN
      check("lu3_stall_count", sc3, 32'd5);
`endif
      check_model(); tick();

      // Load-use with single-cycle stall.
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
      check("lu1_stall", {28'd0, g1}, 32'h1);
      check_model(); tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("lu1_after", {28'd0, g1}, 32'hC);
      check_model(); tick();
      for (int i = 0; i < 3; i++) begin
         drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
         check_model(); tick();
      end

      // Loads with no real hazard.
      drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
      check("nohaz_r0_lu1", {28'd0, g1}, 32'hC);
      check("nohaz_r0_lu3", {28'd0, g3}, 32'hC);
      check_model(); tick();
      drive(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
      check("nohaz_rt_lu3", {28'd0, g3}, 32'hC);
      check_model(); tick();
      drive(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      check("haz_rt_lu1", {28'd0, g1}, 32'h1);
      check_model(); tick();
      for (int i = 0; i < 3; i++) begin
         drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
         check_model(); tick();
      end

      // Branch together with a load-use hazard: flush wins, no stall.
      drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
      check("br_vs_lu_lu3", {28'd0, g3}, 32'hF);
      check_model(); tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      check("br_after_state", {30'd0, st3}, 32'd0);
      check("br_after_grp", {28'd0, g3}, 32'hC);
      check_model(); tick();

      // Reset in the middle of a memory wait.
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      check_model(); tick();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
      check("wait_state", {30'd0, st3}, 32'd2);
      check_model();
      do_reset();

      // Randomized traffic with a small register space to provoke hazards.
      for (int i = 0; i < 600; i++) begin
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 6) == 0));
         check_model();
         tick();
         if (i == 300) begin
            drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            do_reset();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the five-stage datapath. Decodes load-use hazards, taken branches and data-memory wait, and drives the write-enable, flush and bubble controls of the PC, the IF/ID register and the ID/EX register. It sits beside the ID stage and sees the ID operands, the EX load destination and the memory busy flag. A small FSM extends load-use stalls to a configurable length and freezes the pipe across memory waits.

## Interface
- LU_STALL_CYCLES, 1, load-use stall length in cycles; legal range 1..3 (1 with forwarding, 2 without).
- REG_W, 5, register-index width.
- PERF_W, 32, performance-counter width; used only with the macro.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- id_rs  in  REG_W  source register of the instruction in ID
- id_rt  in  REG_W  second source register of the instruction in ID
- id_uses_rt  in  1  ID instruction reads id_rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REG_W  load destination in EX
- branch_taken  in  1  branch/jump resolved taken in EX
- dmem_busy  in  1  data memory not ready; whole pipe must hold
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID synchronous clear to NOP
- id_ex_bubble  out  1  ID/EX loads a NOP
- ctrl_state  out  2  current FSM state, for debug

## Operation
- lu_hit = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- States: RUN=0, LU_STALL=1, MEM_WAIT=2. Code 3 is unused and recovers to RUN.
- Output groups:
  - NORMAL: pc_write=1, if_id_write=1, flush=0, bubble=0.
  - STALL: pc_write=0, if_id_write=0, flush=0, bubble=1.
  - FREEZE: all four outputs 0.
  - FLUSH: pc_write=1, if_id_write=1, flush=1, bubble=1.
- Priority, checked in every state: dmem_busy > branch_taken > stall logic.
- RUN:
  - dmem_busy: FREEZE; set resume=RUN; next MEM_WAIT.
  - else branch_taken: FLUSH; stay in RUN.
  - else lu_hit: STALL; if LU_STALL_CYCLES>1, load cnt=LU_STALL_CYCLES-1 and go to LU_STALL.
  - else: NORMAL.
- LU_STALL:
  - dmem_busy: FREEZE; set resume=LU_STALL; cnt holds; next MEM_WAIT.
  - else branch_taken: FLUSH; clear cnt; next RUN.
  - else STALL while cnt>1, decrementing cnt. In the cycle where cnt==1, output STALL; next RUN.
- MEM_WAIT:
  - dmem_busy=1: FREEZE.
  - dmem_busy=0: outputs and next state are decoded exactly as the resume state would decode the same inputs. No recovery cycle is added.
- Outputs are Mealy, combinational from the state and the current inputs. State, cnt and resume are registered.

## Timing
- Reset (reset=0): state=RUN, cnt=0, resume=RUN, perf counters 0. Outputs follow RUN decode, so with quiet inputs they are NORMAL and ctrl_state=0.
- Reset asserted mid-stall or mid-wait aborts immediately. The first cycle after reset release is RUN.
- Hazard response has zero cycles of latency: STALL appears in the same cycle as lu_hit.
- Total stall length for a load-use hazard is exactly LU_STALL_CYCLES cycles, excluding any FREEZE cycles inserted by memory waits.
- FLUSH lasts exactly one cycle per branch_taken cycle.
- branch_taken and lu_hit in the same cycle: FLUSH wins and no stall is started.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs stall_count and flush_count, each PERF_W wide and saturating, cleared by reset.
  - stall_count increments on every cycle with pc_write=0 (STALL or FREEZE).
  - flush_count increments on every cycle with if_id_flush=1.
- Undefined: neither port nor either counter exists. Behaviour is otherwise identical.

## Structure
- pipe_ctrl_pkg holds:
  - the state enum (RUN, LU_STALL, MEM_WAIT);
  - REG_W default;
  - output-group constants NORMAL, STALL, FREEZE, FLUSH as a 4-bit {pc_write, if_id_write, flush, bubble} vector.
- Sub-module hazard_detect is combinational and produces lu_hit from id_rs, id_rt, id_uses_rt, ex_mem_read and ex_rt.

## Test plan
- Load-use, LU_STALL_CYCLES=1: ex_mem_read=1, ex_rt=5, id_rs=5 -> one cycle of STALL (pc_write=0, bubble=1), then NORMAL.
- Load with no real hazard: ex_rt=0, id_rs=0 -> NORMAL. Also ex_rt=7, id_rt=7 with id_uses_rt=0 -> NORMAL.
- Load-use with LU_STALL_CYCLES=3 and dmem_busy pulsed for 2 cycles during the 2nd stall cycle -> STALL, FREEZE, FREEZE, STALL, STALL, then RUN. With the macro, stall_count=5.
- Branch vs hazard: branch_taken=1 together with lu_hit=1 -> FLUSH (flush=1, bubble=1, pc_write=1) for one cycle, state stays RUN.
- Reset mid-wait: MEM_WAIT with dmem_busy=1, then reset=0 -> ctrl_state=0 and outputs NORMAL with idle inputs; the perf counters read 0.
